// File: rtl/load_store_unit.sv
// load_store_unit
//   MEM-stage controller between the EX/MEM latch and a byte-wide data memory.
//   Serialises LB/LBU/LH/LHU/LW/SB/SH/SW into one byte access per cycle
//   (little-endian), extends load results and rejects misaligned requests.
//   The upstream pipeline is stalled until the access completes.
// Ports
//   clk_i, rst_i           clock (rising edge), async active-high reset
//   req_*                  request from EX/MEM latch; accepted on valid & ready
//   stall_o                freeze upstream pipeline
//   resp_valid_o           one-cycle completion pulse
//   resp_rdata_o           extended load data, held until the next response
//   misalign_o             qualifies resp_valid_o: request rejected
//   mem_*                  byte-wide memory port, read data one cycle after mem_re_o
module load_store_unit #(
  parameter int ADDR_W = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_write_i,
  input  logic [1:0]        req_size_i,
  input  logic              req_unsigned_i,
  input  logic [31:0]       req_addr_i,
  input  logic [31:0]       req_wdata_i,
  output logic              stall_o,
  output logic              resp_valid_o,
  output logic [31:0]       resp_rdata_o,
  output logic              misalign_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [7:0]        mem_wdata_o,
  output logic              mem_we_o,
  output logic              mem_re_o,
  input  logic [7:0]        mem_rdata_i
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_DONE} state_t;

  state_t            state, state_nxt;
  logic [1:0]        idx, idx_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        size_q;
  logic              uns_q, write_q, mis_q;
  logic [3:0][7:0]   wdata_q;
  logic [3:0][7:0]   lane_q;
  logic              cap_vld;
  logic [1:0]        cap_lane;
  logic [31:0]       rdata_q, rdata_ext;
  logic              accept, req_mis;
  logic [1:0]        last_idx;

  // Only the low ADDR_W address bits reach the memory.
  logic unused_addr;
  assign unused_addr = ^req_addr_i[31:ADDR_W];

  assign accept  = (state == S_IDLE) && req_valid_i;
  assign req_mis = (req_size_i == 2'b11) ||
                   (req_size_i == 2'b01 && req_addr_i[0]) ||
                   (req_size_i == 2'b10 && req_addr_i[1:0] != 2'b00);

  always_comb begin
    case (size_q)
      2'b00:   last_idx = 2'd0;
      2'b01:   last_idx = 2'd1;
      default: last_idx = 2'd3;
    endcase
  end

  // Response value presented in DONE; stores leave the previous value in place.
  always_comb begin
    rdata_ext = rdata_q;
    if (mis_q) begin
      rdata_ext = '0;
    end else if (!write_q) begin
      case (size_q)
        2'b00:   rdata_ext = {{24{~uns_q & lane_q[0][7]}}, lane_q[0]};
        2'b01:   rdata_ext = {{16{~uns_q & lane_q[1][7]}}, lane_q[1], lane_q[0]};
        default: rdata_ext = lane_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= S_IDLE;
      idx      <= '0;
      addr_q   <= '0;
      size_q   <= '0;
      uns_q    <= 1'b0;
      write_q  <= 1'b0;
      mis_q    <= 1'b0;
      wdata_q  <= '0;
      lane_q   <= '0;
      cap_vld  <= 1'b0;
      cap_lane <= '0;
      rdata_q  <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      if (accept) begin
        addr_q  <= req_addr_i[ADDR_W-1:0];
        size_q  <= req_size_i;
        uns_q   <= req_unsigned_i;
        write_q <= req_write_i;
        wdata_q <= req_wdata_i;
        mis_q   <= req_mis;
      end
      // Read data lags the strobe by one cycle, so remember which lane it belongs to.
      cap_vld  <= mem_re_o;
      cap_lane <= idx;
      if (cap_vld) lane_q[cap_lane] <= mem_rdata_i;
      if (state == S_DONE) rdata_q <= rdata_ext;
    end
  end

  always_comb begin
    state_nxt    = state;
    idx_nxt      = idx;
    req_ready_o  = 1'b0;
    stall_o      = 1'b0;
    resp_valid_o = 1'b0;
    misalign_o   = 1'b0;
    resp_rdata_o = rdata_q;
    mem_addr_o   = '0;
    mem_wdata_o  = '0;
    mem_we_o     = 1'b0;
    mem_re_o     = 1'b0;
    case (state)
      S_IDLE: begin
        req_ready_o = 1'b1;
        stall_o     = req_valid_i;
        if (req_valid_i) begin
          idx_nxt   = '0;
          state_nxt = req_mis ? S_DONE : S_ACCESS;
        end
      end
      S_ACCESS: begin
        stall_o    = 1'b1;
        mem_addr_o = addr_q + ADDR_W'(idx);
        if (write_q) begin
          mem_we_o    = 1'b1;
          mem_wdata_o = wdata_q[idx];
        end else begin
          mem_re_o = 1'b1;
        end
        idx_nxt = idx + 2'd1;
        if (idx == last_idx) begin
          idx_nxt   = '0;
          state_nxt = write_q ? S_DONE : S_WAIT;
        end
      end
      S_WAIT: begin
        // Last load byte lands in the buffer at the end of this cycle.
        stall_o   = 1'b1;
        state_nxt = S_DONE;
      end
      S_DONE: begin
        resp_valid_o = 1'b1;
        misalign_o   = mis_q;
        resp_rdata_o = rdata_ext;
        state_nxt    = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule
